// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into req/gnt/rvalid
// data-bus transactions, with byte-lane steering, load extension and misalignment checks.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic        flush_i,
    output logic        lsu_stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        lsu_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [2:0]  dbg_state_o
);

    // Bus handshake: dmem_req_o and all bus fields stay stable from the IDLE->REQ edge
    // until the cycle dmem_gnt_i is seen high; one dmem_rvalid_i completes each granted read.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_err;

    logic        w_valid;
    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_ext;

    assign w_valid = mem_read_i | mem_write_i;

    always_comb begin
        w_err = 1'b0;
        if (mem_read_i && mem_write_i)
            w_err = 1'b1;
        if (mem_read_i && (funct3_i == 3'd3 || funct3_i == 3'd6 || funct3_i == 3'd7))
            w_err = 1'b1;
        if (mem_write_i && funct3_i >= 3'd3)
            w_err = 1'b1;
        // funct3[1:0] encodes the access size for every legal code (B/BU, H/HU, W)
        if (funct3_i[1:0] == 2'd1 && addr_i[0])
            w_err = 1'b1;
        if (funct3_i[1:0] == 2'd2 && addr_i[1:0] != 2'd0)
            w_err = 1'b1;
    end

    always_comb begin
        w_be    = 4'hF;
        w_wdata = 32'h0;
        if (mem_write_i) begin
            case (funct3_i[1:0])
                2'd0: begin
                    w_be    = 4'b0001 << addr_i[1:0];
                    w_wdata = {4{wdata_i[7:0]}};
                end
                2'd1: begin
                    w_be    = 4'b0011 << addr_i[1:0];
                    w_wdata = {2{wdata_i[15:0]}};
                end
                default: begin
                    w_be    = 4'hF;
                    w_wdata = wdata_i;
                end
            endcase
        end
    end

    assign w_shifted = dmem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        case (r_funct3)
            3'd0:    w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'd1:    w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'd4:    w_ext = {24'h0, w_shifted[7:0]};
            3'd5:    w_ext = {16'h0, w_shifted[15:0]};
            default: w_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0;
            r_be         <= 4'h0;
            r_wdata      <= 32'h0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_load_data  <= 32'h0;
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid && !flush_i) begin
                        if (w_err) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_req    <= 1'b1;
                            r_we     <= mem_write_i;
                            r_addr   <= {addr_i[31:2], 2'b00};
                            r_be     <= w_be;
                            r_wdata  <= w_wdata;
                            r_funct3 <= funct3_i;
                            r_off    <= addr_i[1:0];
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        r_req <= 1'b0;
                        // A granted write cannot be recalled; a granted read must be drained
                        if (r_we)
                            r_state <= flush_i ? S_IDLE : S_DONE;
                        else
                            r_state <= flush_i ? S_DRAIN : S_WAIT;
                    end else if (flush_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        if (flush_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_load_data  <= w_ext;
                            r_load_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end else if (flush_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                S_DRAIN: begin
                    if (dmem_rvalid_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_stall_o  = w_valid & ~flush_i & (r_state != S_DONE);
    assign load_data_o  = r_load_data;
    assign load_valid_o = r_load_valid;
    assign lsu_err_o    = r_err;
    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;
    assign dbg_state_o  = r_state;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the RV32IM pipeline. It consumes the memory-control and data outputs held in the EX/MEM pipeline register and turns each load/store into a request/grant/response transaction on the data-memory bus. It also does byte-lane steering, load extraction and sign extension, and misalignment detection, and stalls the pipeline until each access completes. It sits between the EX/MEM and MEM/WB registers and drives load data toward write-back.

## Interface
- Parameters: none.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_read_i  in  1  load present in MEM stage
- mem_write_i  in  1  store present in MEM stage
- addr_i  in  32  effective byte address (ALU result)
- wdata_i  in  32  store data (rs2)
- funct3_i  in  3  access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
- flush_i  in  1  abort current MEM-stage access
- lsu_stall_o  out  1  hold IF..EX/MEM registers (combinational)
- load_data_o  out  32  extracted, extended load result (registered)
- load_valid_o  out  1  load_data_o updated this cycle
- lsu_err_o  out  1  one-cycle pulse: misaligned or illegal access
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address, bits [1:0] = 0
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated write data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data word

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN. Reset puts the FSM in IDLE and forces all outputs to 0.
- Access valid = mem_read_i | mem_write_i.
- Error conditions:
  - Both mem_read_i and mem_write_i are set.
  - Load funct3 is 3, 6 or 7.
  - Store funct3 is 3 or higher.
  - H/HU with addr_i[0] = 1.
  - W with addr_i[1:0] ≠ 0.
- IDLE, access valid, no flush_i:
  - Error: go to DONE and pulse lsu_err_o in DONE. No bus request is issued.
  - Otherwise: register the bus fields and go to REQ.
- Bus fields:
  - dmem_addr_o = {addr_i[31:2], 2'b00}.
  - dmem_we_o = mem_write_i.
  - Byte enables: SB = 0001 << addr[1:0]; SH = 0011 << addr[1:0]; SW = 1111; loads = 1111.
  - Write data: SB = {4{wdata_i[7:0]}}; SH = {2{wdata_i[15:0]}}; SW = wdata_i.
- REQ: dmem_req_o = 1. All bus fields are held stable until grant.
  - gnt & write: go to DONE.
  - gnt & read: go to WAIT.
- WAIT: on rvalid, capture the extracted value into load_data_o and go to DONE.
  - Shift: rdata >> (8*addr[1:0]).
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- DONE: lsu_stall_o = 0. load_valid_o = 1 for loads only. Next state is IDLE.
- lsu_stall_o = access valid & !flush_i & state ∈ {IDLE, REQ, WAIT, DRAIN}.
  - It is 0 in DONE, so the EX/MEM register advances on that edge.
  - An access is never reissued.
- Flush handling:
  - IDLE: no action.
  - REQ without gnt: drop req and go to IDLE.
  - REQ with gnt on a read: go to DRAIN.
  - REQ with gnt on a write: the write completes and the FSM goes to IDLE.
  - WAIT: go to DRAIN.
  - DONE: no effect.
- DRAIN: discard the next rvalid and go to IDLE. No load_valid_o. Stall is asserted if a new access is presented.
- load_data_o holds its value until the next completed load.
- An rvalid arriving outside WAIT or DRAIN is ignored.
- Reset mid-transaction returns the FSM to IDLE immediately. Stale responses are ignored.

## Timing
- Latency with a zero-wait memory (gnt in the REQ cycle, rvalid one cycle later):
  - Store: stall 2 cycles (IDLE, REQ), DONE in cycle 3.
  - Load: stall 3 cycles (IDLE, REQ, WAIT), DONE in cycle 4, load_data_o valid from cycle 4.
- Each extra cycle without gnt, or without rvalid, adds one stall cycle.
- Error access: stall 1 cycle, then DONE with lsu_err_o = 1. dmem_req_o never rises.
- Back-to-back accesses: a new access is accepted in the IDLE cycle following DONE.
- Bus fields change only on the IDLE→REQ edge.

## Test plan
- LW at 0x100, rdata = 0xDEADBEEF, gnt immediate, rvalid next cycle:
  - req in cycle 2, addr 0x100, be 1111.
  - load_data_o = 0xDEADBEEF, load_valid_o in cycle 4, stall cycles 1–3.
- SB wdata 0x000000A5 at 0x203:
  - be 1000, wdata 0xA5A5A5A5, we = 1, stall 2 cycles.
- LB / LBU at 0x301 with rdata 0x00008000:
  - LB: load_data_o 0xFFFFFF80.
  - LBU: load_data_o 0x00000080.
- LH at 0x101 and SW at 0x102:
  - lsu_err_o pulses, no dmem_req_o, 1 stall cycle each.
- Load with gnt delayed 3 cycles:
  - req and addr held stable for 3 cycles.
  - flush_i raised in WAIT: FSM goes to DRAIN, the following rvalid is discarded, no load_valid_o, and the next LW completes normally.
- Reset asserted while in WAIT:
  - all outputs 0 and FSM in IDLE.
  - A stray rvalid after reset leaves load_data_o = 0.
